// File: rtl/l2_arbiter_pkg.sv
// Shared LC-3b memory-side types used by the L1/L2 arbiter.
package l2_arbiter_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DRAIN} lc3b_arb_state;
  typedef enum logic       {GRANT_I, GRANT_D}              lc3b_arb_grant;
endpackage

// File: rtl/l2_arbiter_control.sv
// Arbiter FSM: picks a requester in IDLE, waits for l2_resp, then holds a drain gap.
module l2_arbiter_control
  import l2_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN  = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_i,
  input  logic          d_req_i,
  input  logic          l2_resp_i,
  output lc3b_arb_state state_o,
  output lc3b_arb_grant grant_o,
  output logic          load_o,
  output logic          clear_o,
  output logic          conflict_o
);
  lc3b_arb_state state_q, state_d;
  lc3b_arb_grant last_q, last_d, grant;
  logic [1:0]    cnt_q, cnt_d;
  logic          conflict_q, conflict_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= GRANT_I;
      cnt_q      <= 2'd0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    conflict_d = 1'b0;
    grant      = GRANT_I;
    load_o     = 1'b0;
    clear_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          load_o = 1'b1;
          if (i_req_i && d_req_i) begin
            conflict_d = 1'b1;
            // Fixed-priority mode always favours the D-cache on a tie.
            grant = (ROUND_ROBIN != 0 && last_q == GRANT_D) ? GRANT_I : GRANT_D;
          end else begin
            grant = d_req_i ? GRANT_D : GRANT_I;
          end
          state_d = (grant == GRANT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp_i) begin
          clear_o = 1'b1;
          last_d  = (state_q == SERVE_D) ? GRANT_D : GRANT_I;
          cnt_d   = 2'(DRAIN_CYCLES - 1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign grant_o    = grant;
  assign conflict_o = conflict_q;
endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the I-cache and D-cache; request fields are latched at grant.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN  = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output logic          i_resp,
  output lc3b_cacheline i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_cacheline d_wdata,
  output logic          d_resp,
  output lc3b_cacheline d_rdata,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_cacheline l2_wdata,
  input  logic          l2_resp,
  input  lc3b_cacheline l2_rdata,
  output logic          conflict_inc
);
  lc3b_arb_state state;
  lc3b_arb_grant grant;
  logic          load, clear;
  logic          read_q, write_q;
  lc3b_word      addr_q;
  lc3b_cacheline wdata_q;

  l2_arbiter_control #(
    .ROUND_ROBIN (ROUND_ROBIN),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_i   (i_read),
    .d_req_i   (d_read | d_write),
    .l2_resp_i (l2_resp),
    .state_o   (state),
    .grant_o   (grant),
    .load_o    (load),
    .clear_o   (clear),
    .conflict_o(conflict_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      if (grant == GRANT_D) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        // Read+write together is illegal from the D-cache; the write wins.
        read_q  <= d_read & ~d_write;
        write_q <= d_write;
      end else begin
        addr_q  <= i_address;
        read_q  <= 1'b1;
        write_q <= 1'b0;
      end
    end else if (clear) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign l2_read    = read_q;
  assign l2_write   = write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  assign i_resp  = (state == SERVE_I) & l2_resp;
  assign d_resp  = (state == SERVE_D) & l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: round-robin and fixed-priority instances share stimulus and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_l2_arbiter;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, l2_resp = 1'b0;
  logic [15:0]  i_address = '0, d_address = '0;
  logic [127:0] d_wdata = '0, l2_rdata = '0;

  logic i_resp1, d_resp1, l2_read1, l2_write1, conf1;
  logic [15:0] l2_addr1;
  logic [127:0] i_rdata1, d_rdata1, l2_wdata1;
  logic i_resp0, d_resp0, l2_read0, l2_write0, conf0;
  logic [15:0] l2_addr0;
  logic [127:0] i_rdata0, d_rdata0, l2_wdata0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ROUND_ROBIN(1), .DRAIN_CYCLES(DC)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp1), .i_rdata(i_rdata1),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp1), .d_rdata(d_rdata1),
    .l2_read(l2_read1), .l2_write(l2_write1), .l2_address(l2_addr1), .l2_wdata(l2_wdata1),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .conflict_inc(conf1)
  );

  l2_arbiter #(.ROUND_ROBIN(0), .DRAIN_CYCLES(DC)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp0), .i_rdata(i_rdata0),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp0), .d_rdata(d_rdata0),
    .l2_read(l2_read0), .l2_write(l2_write0), .l2_address(l2_addr0), .l2_wdata(l2_wdata0),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .conflict_inc(conf0)
  );

  // Model: one transaction in flight or a countdown of idle cycles before the next pick.
  typedef struct {
    bit           busy;
    bit           side_d;
    int           gap;
    bit           last_d;
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    bit           conf;
  } mdl_t;

  mdl_t m1, m0;

  function automatic mdl_t mreset();
    mdl_t n;
    n.busy = 0; n.side_d = 0; n.gap = 0; n.last_d = 0;
    n.rd = 0; n.wr = 0; n.addr = '0; n.wdata = '0; n.conf = 0;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit rr);
    mdl_t n = m;
    bit ireq = i_read;
    bit dreq = d_read | d_write;
    bit pick_d;
    n.conf = 0;
    if (m.busy) begin
      if (l2_resp) begin
        n.busy = 0; n.gap = DC; n.last_d = m.side_d; n.rd = 0; n.wr = 0;
      end
    end else if (m.gap > 0) begin
      n.gap = m.gap - 1;
    end else if (ireq || dreq) begin
      if (ireq && dreq) begin
        n.conf = 1;
        pick_d = rr ? !m.last_d : 1'b1;
      end else begin
        pick_d = dreq;
      end
      n.busy = 1; n.side_d = pick_d;
      if (pick_d) begin
        n.addr = d_address; n.wdata = d_wdata; n.wr = d_write; n.rd = !d_write;
      end else begin
        n.addr = i_address; n.rd = 1; n.wr = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = mreset();
      m0 = mreset();
    end else begin
      m1 = mstep(m1, 1'b1);
      m0 = mstep(m0, 1'b0);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [127:0] wd, input logic cf,
                         input logic ir, input logic dr, input logic [127:0] ird,
                         input logic [127:0] drd);
    chk({tag, ".l2_read"},    rd,  m.busy & m.rd);
    chk({tag, ".l2_write"},   wr,  m.busy & m.wr);
    chk({tag, ".l2_address"}, a,   m.addr);
    chk({tag, ".l2_wdata"},   wd,  m.wdata);
    chk({tag, ".conflict"},   cf,  m.conf);
    chk({tag, ".i_resp"},     ir,  m.busy & !m.side_d & l2_resp);
    chk({tag, ".d_resp"},     dr,  m.busy & m.side_d & l2_resp);
    chk({tag, ".i_rdata"},    ird, l2_rdata);
    chk({tag, ".d_rdata"},    drd, l2_rdata);
  endtask

  always @(negedge clk) begin
    cmp_dut("rr", m1, l2_read1, l2_write1, l2_addr1, l2_wdata1, conf1,
            i_resp1, d_resp1, i_rdata1, d_rdata1);
    cmp_dut("fp", m0, l2_read0, l2_write0, l2_addr0, l2_wdata0, conf0,
            i_resp0, d_resp0, i_rdata0, d_rdata0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m1 = mreset();
    m0 = mreset();
    repeat (2) tick();
    chk("rst.l2_read",  l2_read1, 1'b0);
    chk("rst.l2_addr",  l2_addr1, 16'h0);
    chk("rst.conflict", conf1,    1'b0);
    rst_n = 1'b1;

    // Single I read with mid-service address change
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    chk("iread.l2_read", l2_read1, 1'b1);
    chk("iread.l2_addr", l2_addr1, 16'h1230);
    i_address = 16'h9990;
    repeat (5) tick();
    chk("iread.hold_addr", l2_addr1, 16'h1230);
    l2_resp = 1'b1; l2_rdata = {16{8'hA5}}; i_read = 1'b0;
    #1;
    chk("iread.i_resp",  i_resp1,  1'b1);
    chk("iread.d_resp",  d_resp1,  1'b0);
    chk("iread.i_rdata", i_rdata1, {16{8'hA5}});
    tick();
    l2_resp = 1'b0;
    chk("iread.drop", l2_read1, 1'b0);
    repeat (2) tick();

    // D write
    d_write = 1'b1; d_address = 16'h4440; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    tick();
    chk("dwr.l2_write", l2_write1, 1'b1);
    chk("dwr.l2_read",  l2_read1,  1'b0);
    chk("dwr.l2_addr",  l2_addr1,  16'h4440);
    chk("dwr.l2_wdata", l2_wdata1, 128'h0123456789ABCDEF0123456789ABCDEF);
    repeat (2) tick();
    l2_resp = 1'b1; d_write = 1'b0;
    #1;
    chk("dwr.d_resp", d_resp1, 1'b1);
    chk("dwr.i_resp", i_resp1, 1'b0);
    tick();
    l2_resp = 1'b0;
    chk("dwr.drop", l2_write1, 1'b0);

    // Conflicts out of reset
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    i_read = 1'b1; d_read = 1'b1; i_address = 16'h1230; d_address = 16'h4440;
    tick();
    chk("cf1.rr_addr", l2_addr1, 16'h4440);
    chk("cf1.rr_read", l2_read1, 1'b1);
    chk("cf1.rr_conf", conf1,    1'b1);
    chk("cf1.fp_addr", l2_addr0, 16'h4440);
    chk("cf1.fp_conf", conf0,    1'b1);
    tick();
    chk("cf1.conf_pulse", conf1, 1'b0);
    l2_resp = 1'b1; d_read = 1'b0;
    tick();
    l2_resp = 1'b0; d_read = 1'b1;
    chk("cf1.gap1", l2_read1, 1'b0);
    tick();
    chk("cf1.gap2", l2_read1, 1'b0);
    tick();
    chk("cf1.idle", l2_read1, 1'b0);
    tick();
    chk("cf2.rr_read", l2_read1, 1'b1);
    chk("cf2.rr_addr", l2_addr1, 16'h1230);
    chk("cf2.rr_conf", conf1,    1'b1);
    chk("cf2.fp_addr", l2_addr0, 16'h4440);
    chk("cf2.fp_conf", conf0,    1'b1);
    l2_resp = 1'b1; i_read = 1'b0; d_read = 1'b0;
    tick();
    l2_resp = 1'b0;
    repeat (3) tick();

    // Reset during SERVE_D, between clock edges
    d_write = 1'b1; d_address = 16'h4440;
    tick();
    chk("rmid.pre", l2_write1, 1'b1);
    d_write = 1'b0;
    #1 rst_n = 1'b0; l2_resp = 1'b1;
    #1;
    chk("rmid.l2_write", l2_write1, 1'b0);
    chk("rmid.d_resp",   d_resp1,   1'b0);
    chk("rmid.l2_addr",  l2_addr1,  16'h0);
    #1 rst_n = 1'b1; l2_resp = 1'b0; i_read = 1'b1; i_address = 16'h0BEE;
    tick();
    chk("rmid.fresh_read", l2_read1, 1'b1);
    chk("rmid.fresh_addr", l2_addr1, 16'h0BEE);
    l2_resp = 1'b1; i_read = 1'b0;
    tick();
    l2_resp = 1'b0;
    repeat (3) tick();

    // Randomized traffic, including illegal read+write and stray l2_resp
    repeat (3000) begin
      i_read    = ($urandom_range(0, 2) == 0);
      d_read    = ($urandom_range(0, 2) == 0);
      d_write   = ($urandom_range(0, 3) == 0);
      i_address = 16'($urandom);
      d_address = 16'($urandom);
      d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      l2_rdata  = {$urandom, $urandom, $urandom, $urandom};
      l2_resp   = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Arbitrates between the L1 instruction cache (read-only) and the L1 data cache (read/write) for the single L2 cache port.
- Sits directly upstream of the L2 cache. Presents one latched cacheline request at a time and routes the L2 response back to the granted requester.
- Inserts a drain gap after every response, because the L2 registers its inputs one cycle late.
- Produces performance-counter pulses for arbitration conflicts.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate grant on conflict; 0 = fixed D-cache priority.
- DRAIN_CYCLES, 2: cycles with all L2 request outputs low after each l2_resp; legal range 1..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request
- i_address  in  16  I-cache line address (lc3b_word)
- i_resp  out  1  I-cache response
- i_rdata  out  128  I-cache read data (lc3b_cacheline)
- d_read  in  1  D-cache read request
- d_write  in  1  D-cache write request
- d_address  in  16  D-cache line address
- d_wdata  in  128  D-cache write data
- d_resp  out  1  D-cache response
- d_rdata  out  128  D-cache read data
- l2_read  out  1  request to L2
- l2_write  out  1  request to L2
- l2_address  out  16  request to L2
- l2_wdata  out  128  request to L2
- l2_resp  in  1  L2 response
- l2_rdata  in  128  L2 read data
- conflict_inc  out  1  one-cycle pulse when both caches request in IDLE

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; l2_read=0, l2_write=0, l2_address=0, l2_wdata=0; last_grant=I (so the first conflict goes to D); drain counter=0; conflict_inc=0.
- FSM states: IDLE, SERVE_I, SERVE_D, DRAIN.
- IDLE, no request pending: stay in IDLE.
- IDLE, only i_read: go to SERVE_I. Latch i_address into the l2_address register; l2_read=1.
- IDLE, only d_read or d_write: go to SERVE_D. Latch d_address and d_wdata; l2_read=d_read, l2_write=d_write.
  - d_read and d_write both high is illegal. Treat it as a write.
- IDLE, both caches requesting:
  - ROUND_ROBIN=1: grant the side not equal to last_grant.
  - ROUND_ROBIN=0: grant D.
  - conflict_inc pulses for one cycle, registered on the same edge as the grant.
- Grant latency: a request sampled high at edge k gives l2_* asserted from cycle k+1. All L2-side outputs are registers only.
- SERVE_x: l2_* hold their latched values, ignoring any further changes on the L1 inputs, until l2_resp=1.
  - i_resp = (state==SERVE_I) & l2_resp, combinational.
  - d_resp = (state==SERVE_D) & l2_resp, combinational.
  - i_rdata = l2_rdata and d_rdata = l2_rdata, unconditionally.
  - On the l2_resp edge: last_grant updates, l2_read and l2_write are cleared, and the FSM goes to DRAIN with the counter loaded with DRAIN_CYCLES-1.
- DRAIN: l2_read=0, l2_write=0. Decrement the counter and go to IDLE when it is 0. Requests that arrive during DRAIN wait.
- Minimum spacing: if l2_resp is seen in cycle N, the next l2_read or l2_write rises no earlier than cycle N+1+DRAIN_CYCLES+1. The extra cycle is the IDLE sample.
- Requester drops its request mid-service: the transaction is still completed. The matching *_resp pulses once and may be ignored by the requester.
- l2_resp while in IDLE or DRAIN: ignored; no *_resp is generated.
- Reset mid-transaction: immediate return to reset values; the pending transfer is abandoned.
- A requester whose request is still high after its own resp is re-arbitrated as a new request after DRAIN. L1 controllers must deassert on resp.

Decomposition:
- Shared lc3b_types package gains:
  - enum lc3b_arb_state {IDLE, SERVE_I, SERVE_D, DRAIN}
  - enum lc3b_arb_grant {GRANT_I, GRANT_D}
- lc3b_word and lc3b_cacheline are reused from the package.
- One sub-module, l2_arbiter_control: holds the FSM, last_grant, drain counter and conflict_inc, and outputs grant/load/clear strobes.
- The datapath registers (address/wdata/read/write) stay in the top level.

Test Plan:
- Single I read: i_read=1 with i_address=16'h1230; L2 responds 5 cycles after l2_read rises with l2_rdata=128'hA5..A5. Expect:
  - l2_read=1, l2_address=16'h1230 one cycle after the request.
  - i_resp=1 with i_rdata=128'hA5..A5 in the response cycle; d_resp=0.
- D write: d_write=1, d_address=16'h4440, d_wdata=128'h0123..CDEF. Expect l2_write=1 with those exact values and l2_read=0. d_resp pulses exactly once on l2_resp.
- Conflict with ROUND_ROBIN=1: both request out of reset, both held until their resp. Expect:
  - D granted first, with conflict_inc=1 for one cycle.
  - After D's resp: l2 outputs low for 2 cycles, then the I request granted.
  - A second simultaneous conflict goes to I after D was last.
- Conflict with ROUND_ROBIN=0: repeated simultaneous requests are always granted to D. The I-side grant happens only when d_read and d_write are both 0 in IDLE.
- Input stability: change i_address from 16'h1230 to 16'h9990 mid-service. Expect l2_address to stay 16'h1230 until l2_resp.
- Reset mid-service: pull rst_n low during SERVE_D with no clock edge. Expect l2_write=0 immediately and no d_resp. After release, a fresh request is granted in 1 cycle.
